// File: rtl/code_loader_pkg.sv
// code_loader_pkg: shared types and constants for the byte-serial program loader.
//   state_t        - loader FSM states
//   SYNC_BYTE      - frame start marker
//   BYTES_PER_WORD - payload bytes carried per instruction word
//   in_frame()     - true in the states where the inter-byte timeout is armed
package code_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    B0,
    B1,
    B2,
    CHK,
    RUN,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 3;

  function automatic logic in_frame(input state_t s);
    return (s inside {LEN_LO, LEN_HI, B0, B1, B2, CHK});
  endfunction

endpackage

// File: rtl/code_loader.sv
// code_loader: assembles 18-bit instruction words from a framed UART byte
// stream, writes them into code RAM and holds the processor in reset until a
// complete frame with a good checksum has been stored.
// Frame: A5 | LEN_LO LEN_HI | N x (b0 b1 b2) | CHK (XOR of all payload bytes).
// Ports:
//   clock      - single clock, rising edge
//   reset      - asynchronous, active-low
//   rx_valid   - one-cycle strobe qualifying rx_data
//   rx_data    - received byte
//   code_we    - one-cycle code RAM write strobe
//   code_addr  - code RAM write address
//   code_din   - code RAM write data
//   cpu_reset  - active-high processor reset
//   busy       - a frame is being received
//   done       - last frame loaded successfully
//   error      - last frame aborted (bad length, bad checksum or timeout)
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_SIZE      = 18,
  parameter int WORD_SIZE      = 18,
  parameter int MEM_SIZE       = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 code_we,
  output logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_din,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // Bits of the last payload byte that land in the word (2 for an 18-bit word).
  localparam int TOP_BITS = WORD_SIZE - 8 * (BYTES_PER_WORD - 1);
  localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  // One extra bit so that MEM_SIZE = 65536 would still compare correctly.
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);

  state_t             state_reg;
  logic [7:0]         len_lo_reg;
  logic [7:0]         b0_reg;
  logic [7:0]         b1_reg;
  logic [7:0]         chk_reg;
  logic [15:0]        len_reg;
  logic [15:0]        index_reg;
  logic [IDLE_W-1:0]  idle_cnt_reg;

  logic [15:0] len_next;
  logic [15:0] index_next;
  logic        is_sync;
  logic        timeout_hit;

  assign len_next   = {rx_data, len_lo_reg};
  assign index_next = index_reg + 16'd1;
  assign is_sync    = rx_valid && (rx_data == SYNC_BYTE);
  // Fires on the edge where the idle counter would reach TIMEOUT_CYCLES, so
  // error becomes visible in the same cycle the counter does.
  assign timeout_hit = in_frame(state_reg) && !rx_valid && (idle_cnt_reg == IDLE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      len_lo_reg   <= '0;
      b0_reg       <= '0;
      b1_reg       <= '0;
      chk_reg      <= '0;
      len_reg      <= '0;
      index_reg    <= '0;
      idle_cnt_reg <= '0;
      code_we      <= 1'b0;
      code_addr    <= '0;
      code_din     <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      code_we <= 1'b0;

      if (in_frame(state_reg)) begin
        if (rx_valid) idle_cnt_reg <= '0;
        else          idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end

      if (timeout_hit) begin
        state_reg <= ERROR;
        error     <= 1'b1;
        busy      <= 1'b0;
        cpu_reset <= 1'b1;
      end else begin
        case (state_reg)
          // Outside a frame only SYNC matters. ERROR lasts one cycle but
          // still honours a SYNC arriving in that cycle so no byte is lost.
          IDLE, RUN, ERROR: begin
            if (state_reg == ERROR) state_reg <= IDLE;
            if (is_sync) begin
              state_reg    <= LEN_LO;
              idle_cnt_reg <= '0;
              busy         <= 1'b1;
              cpu_reset    <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
            end
          end

          LEN_LO: begin
            if (rx_valid) begin
              len_lo_reg <= rx_data;
              state_reg  <= LEN_HI;
            end
          end

          LEN_HI: begin
            if (rx_valid) begin
              if ((len_next == 16'd0) || ({1'b0, len_next} > MEM_LIMIT)) begin
                state_reg <= ERROR;
                error     <= 1'b1;
                busy      <= 1'b0;
                cpu_reset <= 1'b1;
              end else begin
                len_reg   <= len_next;
                index_reg <= '0;
                chk_reg   <= '0;
                state_reg <= B0;
              end
            end
          end

          B0: begin
            if (rx_valid) begin
              b0_reg    <= rx_data;
              chk_reg   <= chk_reg ^ rx_data;
              state_reg <= B1;
            end
          end

          B1: begin
            if (rx_valid) begin
              b1_reg    <= rx_data;
              chk_reg   <= chk_reg ^ rx_data;
              state_reg <= B2;
            end
          end

          B2: begin
            if (rx_valid) begin
              // Whole byte enters the checksum even though only the low
              // bits reach the word.
              chk_reg   <= chk_reg ^ rx_data;
              code_we   <= 1'b1;
              code_addr <= ADDR_SIZE'(index_reg);
              code_din  <= {rx_data[TOP_BITS-1:0], b1_reg, b0_reg};
              index_reg <= index_next;
              state_reg <= (index_next == len_reg) ? CHK : B0;
            end
          end

          CHK: begin
            if (rx_valid) begin
              busy <= 1'b0;
              if (rx_data == chk_reg) begin
                state_reg <= RUN;
                cpu_reset <= 1'b0;
                done      <= 1'b1;
              end else begin
                state_reg <= ERROR;
                error     <= 1'b1;
                cpu_reset <= 1'b1;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader. A byte-position reference model predicts
// every output each cycle; directed frames pin the model with literal values,
// then randomized frames (good, corrupted, bad length, truncated, reset hit)
// exercise the loader.
module tb_code_loader;

  localparam int TO    = 40;
  localparam int MEMSZ = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        code_we;
  logic [17:0] code_addr;
  logic [17:0] code_din;
  logic        cpu_reset, busy, done, error;

  always #5 clock = ~clock;

  code_loader #(
    .ADDR_SIZE(18),
    .WORD_SIZE(18),
    .MEM_SIZE(MEMSZ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .code_we(code_we),
    .code_addr(code_addr),
    .code_din(code_din),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the frame as "number of bytes seen after SYNC" rather than states.
  logic        e_we, e_cpu_reset, e_busy, e_done, e_error;
  logic [17:0] e_addr, e_din;
  bit          m_in_load;
  int          m_pos, m_n, m_idle;
  logic [7:0]  m_lo, m_b0, m_b1, m_csum;

  task automatic m_reset();
    e_we = 0; e_addr = 0; e_din = 0;
    e_cpu_reset = 1; e_busy = 0; e_done = 0; e_error = 0;
    m_in_load = 0; m_pos = 0; m_n = 0; m_idle = 0;
    m_lo = 0; m_b0 = 0; m_b1 = 0; m_csum = 0;
  endtask

  task automatic m_abort();
    m_in_load = 0; e_error = 1; e_busy = 0; e_cpu_reset = 1;
  endtask

  task automatic m_step(input logic v, input logic [7:0] b);
    int p;
    e_we = 0;
    if (m_in_load) begin
      if (!v) begin
        m_idle++;
        if (m_idle == TO) m_abort();
      end else begin
        m_idle = 0;
        m_pos++;
        if (m_pos == 1) m_lo = b;
        else if (m_pos == 2) begin
          m_n = int'({b, m_lo});
          m_csum = 0;
          if (m_n == 0 || m_n > MEMSZ) m_abort();
        end else begin
          p = m_pos - 3;
          if (p < 3 * m_n) begin
            m_csum ^= b;
            case (p % 3)
              0: m_b0 = b;
              1: m_b1 = b;
              default: begin
                e_we = 1;
                e_addr = 18'(p / 3);
                e_din = {b[1:0], m_b1, m_b0};
              end
            endcase
          end else if (b == m_csum) begin
            m_in_load = 0; e_cpu_reset = 0; e_done = 1; e_busy = 0;
          end else m_abort();
        end
      end
    end else if (v && b == 8'hA5) begin
      m_in_load = 1; m_pos = 0; m_idle = 0;
      e_busy = 1; e_cpu_reset = 1; e_done = 0; e_error = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_reset();
      else m_step(rx_valid, rx_data);
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  logic [35:0] wlog[$];

  always @(negedge clock) begin
    check("outputs{we,addr,din,cpu_reset,busy,done,error}",
          {code_we, code_addr, code_din, cpu_reset, busy, done, error},
          {e_we, e_addr, e_din, e_cpu_reset, e_busy, e_done, e_error});
    if (code_we === 1'b1) wlog.push_back({code_addr, code_din});
  end

  // ---------------- stimulus helpers ----------------
  // One call = one clock cycle; returns 1 time unit after the consuming edge.
  task automatic drive(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] q[$]);
    foreach (q[i]) drive(1'b1, q[i]);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("async_reset_cpu_reset", 64'(cpu_reset), 64'd1);
    check("async_reset_flags", {busy, done, error, code_we}, 4'b0000);
    check("async_reset_addr_din", {code_addr, code_din}, 36'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic rand_frame(input int k);
    logic [7:0] q[$];
    logic [7:0] cs, b;
    int n, kind, cut;
    n = $urandom_range(1, 6);
    kind = $urandom_range(0, 9);
    if (kind == 1) n = ($urandom_range(0, 1) == 0) ? 0 : MEMSZ + $urandom_range(1, 3);
    q = {8'hA5, 8'(n), 8'(n >> 8)};
    cs = 0;
    if (kind != 1)
      for (int i = 0; i < 3 * n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        cs ^= b;
      end
    q.push_back(kind == 0 ? cs ^ 8'($urandom_range(1, 255)) : cs);
    cut = (kind == 2 || kind == 3) ? $urandom_range(1, q.size() - 1) : q.size();
    $display("frame %0d kind=%0d n=%0d bytes=%0d sent=%0d", k, kind, n, q.size(), cut);
    for (int i = 0; i < cut; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      drive(1'b1, q[i]);
    end
    rx_valid = 1'b0;
    if (kind == 2) idle(TO + 3);
    if (kind == 3) pulse_reset();
    // noise between frames (never SYNC)
    for (int i = 0; i < $urandom_range(0, 2); i++) begin
      b = 8'($urandom);
      drive(1'b1, (b == 8'hA5) ? 8'h00 : b);
    end
    idle($urandom_range(0, 3));
  endtask

  // ---------------- test sequence ----------------
  int wn;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(4);
    check("reset_cpu_reset", 64'(cpu_reset), 64'd1);
    check("reset_done_error_we", {done, error, code_we, busy}, 4'b0000);

    // good frame
    wn = wlog.size();
    send({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h03, 8'h24});
    check("good_cpu_released", {cpu_reset, done, error}, 3'b010);
    check("good_write_count", 64'(wlog.size() - wn), 64'd2);
    if (wlog.size() >= wn + 2) begin
      check("good_write0", wlog[wn], {18'd0, 18'h11234});
      check("good_write1", wlog[wn + 1], {18'd1, 18'h3FFFF});
    end
    idle(3);

    // bad checksum
    wn = wlog.size();
    send({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h03, 8'h25});
    check("badchk_flags", {cpu_reset, done, error}, 3'b101);
    check("badchk_write_count", 64'(wlog.size() - wn), 64'd2);
    idle(3);

    // zero length
    wn = wlog.size();
    send({8'hA5, 8'h00, 8'h00});
    check("len0_error", {error, busy, cpu_reset}, 3'b101);
    idle(2);
    check("len0_no_write", 64'(wlog.size() - wn), 64'd0);

    // length 1025
    send({8'hA5, 8'h01, 8'h04});
    check("len1025_error", {error, busy, cpu_reset}, 3'b101);
    idle(2);

    // timeout after b1 of word 0, then a clean load
    wn = wlog.size();
    send({8'hA5, 8'h01, 8'h00, 8'h34, 8'h12});
    idle(TO - 2);
    check("timeout_not_yet", 64'(error), 64'd0);
    idle(4);
    check("timeout_error", {error, busy, cpu_reset}, 3'b101);
    check("timeout_no_write", 64'(wlog.size() - wn), 64'd0);
    send({8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h01, 8'h27});
    check("after_timeout_done", {cpu_reset, done, error}, 3'b010);
    idle(2);

    // restart from RUN, then reset mid-payload
    drive(1'b1, 8'hA5);
    check("restart_flags", {cpu_reset, busy, done}, 3'b110);
    send({8'h02, 8'h00, 8'h34, 8'h12});
    pulse_reset();
    idle(2);
    wn = wlog.size();
    send({8'hA5, 8'h01, 8'h00, 8'hAA, 8'h55, 8'hFE, 8'h01});
    check("post_reset_done", {cpu_reset, done, error}, 3'b010);
    if (wlog.size() == wn + 1) check("post_reset_write", wlog[wn], {18'd0, 18'h255AA});
    else check("post_reset_write_count", 64'(wlog.size() - wn), 64'd1);
    idle(3);

    for (int k = 0; k < 80; k++) rand_frame(k);
    idle(TO + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_loader.md
# code_loader

Byte-serial program loader for the 18-bit processor. Sits upstream of the code memory and the processor reset:
- accepts a framed byte stream from the UART receiver;
- assembles 18-bit instruction words and writes them into code RAM through its write port;
- holds the processor in reset until a complete frame with a valid checksum has been stored.

## Interface

Parameters:
- ADDR_SIZE, 18, code address width
- WORD_SIZE, 18, instruction width (fixed 18; three bytes per word)
- MEM_SIZE, 1024, code RAM depth in words; largest legal word count
- TIMEOUT_CYCLES, 100000, idle cycles between bytes before a load is aborted

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- rx_valid  in  1  one-cycle strobe; rx_data valid
- rx_data  in  8  received byte
- code_we  out  1  code RAM write enable, one-cycle pulse
- code_addr  out  ADDR_SIZE  write address
- code_din  out  WORD_SIZE  write data
- cpu_reset  out  1  active-high processor reset
- busy  out  1  frame in progress
- done  out  1  last frame loaded successfully
- error  out  1  last frame aborted

## Operation

Frame format, in byte order:
- SYNC = 0xA5
- LEN_LO, LEN_HI: word count N, 16-bit
- N×3 payload bytes: b0 = word[7:0], b1 = word[15:8], b2[1:0] = word[17:16]; b2[7:2] ignored
- CHK = XOR of all payload bytes

Reset values: cpu_reset=1, code_we=0, code_addr=0, code_din=0, busy=0, done=0, error=0, state IDLE.

State machine:
- IDLE: rx_data==0xA5 → LEN_LO. Entering LEN_LO sets busy=1, cpu_reset=1, done=0, error=0. Any other byte is ignored.
- LEN_LO → LEN_HI on the next byte.
- LEN_HI: checks N. N==0 or N>MEM_SIZE → ERROR. Otherwise clear the word index and checksum, then → B0.
- B0 → B1 → B2, one byte each; every payload byte is XORed into the checksum.
- B2 byte: issue a write with code_addr=index and code_din={b2[1:0],b1,b0}, then increment index. index==N after increment → CHK, else → B0.
- CHK byte: equals checksum → RUN; mismatch → ERROR.
- RUN: cpu_reset=0, done=1, busy=0. 0xA5 restarts a load as in IDLE. Other bytes are ignored.
- ERROR: error=1, busy=0, cpu_reset=1, then → IDLE.
- Timeout applies in LEN_LO…CHK: an idle counter, cleared by each rx_valid, reaching TIMEOUT_CYCLES → ERROR.

Boundaries:
- SYNC inside a frame is treated as data, not as a restart.
- Words written before an abort stay in RAM; the processor is never released on a partial or bad frame.
- reset asserted mid-frame returns immediately to reset values; the next load must start with SYNC.

## Timing

- All outputs are registered.
- code_we goes high for exactly one cycle, in the cycle after the rx_valid that carried b2. code_addr and code_din are valid in that same cycle.
- rx_valid may assert on consecutive cycles. Writes never overlap, because each write needs three bytes.
- cpu_reset falls, and done rises, one cycle after the rx_valid carrying a correct CHK.
- error rises one cycle after the offending byte, or in the cycle the idle counter reaches TIMEOUT_CYCLES. It stays high until the next SYNC.
- Load latency from SYNC to processor release: 3N+4 bytes, plus one cycle.

## Structure

- Package code_loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, B0, B1, B2, CHK, RUN, ERROR
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_WORD = 3
- Single module. The timeout counter is inline, with no sub-module.

## Test plan

- After reset, with no input: cpu_reset=1, done=0, error=0, no code_we.
- Frame A5 02 00 | 34 12 01 | FF FF 03 | CHK=(34^12^01^FF^FF^03)=0x24:
  - writes 0x11234 at addr 0 and 0x3FFFF at addr 1;
  - cpu_reset falls one cycle after CHK; done=1.
- Same frame with CHK=0x25: both writes occur; error=1, cpu_reset stays 1, done=0.
- Bad lengths: LEN=0x0000 → error after LEN_HI with no writes; LEN=1025 with MEM_SIZE=1024 → error.
- Stop sending after the b1 byte of word 0 and wait TIMEOUT_CYCLES: error=1, no write, then a clean frame loads normally.
- Start a valid frame while in RUN: cpu_reset rises on SYNC. Drive reset low mid-payload: all outputs return to reset values, and a following full frame succeeds.
